dekatron_step_counter: RTL and testbench

DEKATRON_STEP_COUNTER -- requirements
Module: dekatron_step_counter

---
 rtl/dekatron_step_counter_if.sv | 25 ++
 rtl/dekatron_step_counter.sv | 163 ++++++++++++++++
 tb/tb_dekatron_step_counter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dekatron_step_counter_if.sv
// Request/operand/status bundle for the dekatron step counter.
// The master issues operations and observes the live BCD value; the counter is the slave.
interface dekatron_step_counter_if #(
    parameter int WIDTH = 12
);
    logic             Request;
    logic [1:0]       Op;
    logic [3:0]       Step;
    logic [WIDTH-1:0] In;
    logic             Ready;
    logic [WIDTH-1:0] Out;
    logic             Zero;
    logic             AtTop;
    logic             Wrap;

    modport master (
        output Request, Op, Step, In,
        input  Ready, Out, Zero, AtTop, Wrap
    );

    modport slave (
        input  Request, Op, Step, In,
        output Ready, Out, Zero, AtTop, Wrap
    );
endinterface

// File: rtl/dekatron_step_counter.sv
// BCD up/down counter that emulates dekatron tubes: every digit transition takes
// DIGIT_DELAY cycles and carries ripple upward one digit at a time, visible on Out.
module dekatron_step_counter #(
    parameter int                 D_NUM          = 3,
    parameter int                 DEKATRON_WIDTH = 4,
    parameter int                 WIDTH          = D_NUM * DEKATRON_WIDTH,
    parameter logic [WIDTH-1:0]   TOP_VALUE      = {D_NUM{DEKATRON_WIDTH'(9)}},
    parameter int                 LIMIT_MODE     = 0,
    parameter int                 DIGIT_DELAY    = 2
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    dekatron_step_counter_if.slave bus
);

    localparam int IDX_W = (D_NUM > 1) ? $clog2(D_NUM) : 1;
    localparam int CNT_W = (DIGIT_DELAY > 1) ? $clog2(DIGIT_DELAY + 1) : 1;

    localparam logic [WIDTH-1:0]          ALL_NINES  = {D_NUM{DEKATRON_WIDTH'(9)}};
    localparam logic [WIDTH-1:0]          LIMIT      = (LIMIT_MODE == 0) ? ALL_NINES : TOP_VALUE;
    localparam logic [DEKATRON_WIDTH-1:0] DIGIT_NINE = DEKATRON_WIDTH'(9);
    localparam logic [CNT_W-1:0]          LAST_CNT   = CNT_W'(DIGIT_DELAY - 1);
    localparam logic [IDX_W-1:0]          TOP_IDX    = IDX_W'(D_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIGIT,
        CARRY,
        DONE
    } state_t;

    state_t                    state;
    logic                      request_q;
    logic [1:0]                op_q;
    logic [3:0]                steps_left;
    logic [WIDTH-1:0]          in_q;
    logic [WIDTH-1:0]          out_q;
    logic                      wrap_q;
    logic [CNT_W-1:0]          delay_cnt;
    logic [IDX_W-1:0]          digit_idx;

    logic                      is_inc;
    logic [DEKATRON_WIDTH-1:0] cur_digit;
    logic [DEKATRON_WIDTH-1:0] new_digit;
    logic                      digit_wraps;
    logic                      has_higher;
    logic                      at_limit;
    logic [WIDTH-1:0]          stepped_out;
    logic [WIDTH-1:0]          load_value;

    // Next value of the digit under the tube's glow, and the whole word with it replaced.
    always_comb begin
        is_inc      = (op_q == 2'b00);
        cur_digit   = out_q[digit_idx * DEKATRON_WIDTH +: DEKATRON_WIDTH];
        digit_wraps = is_inc ? (cur_digit == DIGIT_NINE) : (cur_digit == '0);
        if (digit_wraps)
            new_digit = is_inc ? '0 : DIGIT_NINE;
        else
            new_digit = is_inc ? cur_digit + DEKATRON_WIDTH'(1) : cur_digit - DEKATRON_WIDTH'(1);
        stepped_out = out_q;
        stepped_out[digit_idx * DEKATRON_WIDTH +: DEKATRON_WIDTH] = new_digit;
        has_higher  = (digit_idx != TOP_IDX);
        at_limit    = is_inc ? (out_q == LIMIT) : (out_q == '0);
    end

    // Valid BCD compares correctly as a plain binary number, so clamping needs no digit walk.
    always_comb begin
        load_value = '0;
        for (int k = 0; k < D_NUM; k++) begin
            if (in_q[k * DEKATRON_WIDTH +: DEKATRON_WIDTH] <= DIGIT_NINE)
                load_value[k * DEKATRON_WIDTH +: DEKATRON_WIDTH] = in_q[k * DEKATRON_WIDTH +: DEKATRON_WIDTH];
        end
        if (LIMIT_MODE != 0 && load_value > TOP_VALUE)
            load_value = TOP_VALUE;
        if (op_q == 2'b11)
            load_value = '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            request_q  <= 1'b0;
            op_q       <= '0;
            steps_left <= '0;
            in_q       <= '0;
            out_q      <= '0;
            wrap_q     <= 1'b0;
            delay_cnt  <= '0;
            digit_idx  <= '0;
        end else begin
            request_q <= bus.Request;
            case (state)
                IDLE: begin
                    if (bus.Request && !request_q) begin
                        op_q       <= bus.Op;
                        steps_left <= (bus.Step == 4'd0) ? 4'd1 : bus.Step;
                        in_q       <= bus.In;
                        wrap_q     <= 1'b0;
                        delay_cnt  <= '0;
                        digit_idx  <= '0;
                        state      <= bus.Op[1] ? LOAD : DIGIT;
                    end
                end
                LOAD: begin
                    if (delay_cnt == LAST_CNT) begin
                        out_q <= load_value;
                        state <= DONE;
                    end else begin
                        delay_cnt <= delay_cnt + CNT_W'(1);
                    end
                end
                DIGIT, CARRY: begin
                    // Saturation is decided on the settled value before any tube moves.
                    if (state == DIGIT && LIMIT_MODE == 2 && delay_cnt == '0 && at_limit) begin
                        wrap_q <= 1'b1;
                        state  <= DONE;
                    end else if (delay_cnt != LAST_CNT) begin
                        delay_cnt <= delay_cnt + CNT_W'(1);
                    end else begin
                        delay_cnt <= '0;
                        if (state == DIGIT && LIMIT_MODE == 1 && at_limit) begin
                            out_q     <= is_inc ? '0 : TOP_VALUE;
                            wrap_q    <= 1'b1;
                            digit_idx <= '0;
                            if (steps_left == 4'd1) begin
                                state <= DONE;
                            end else begin
                                steps_left <= steps_left - 4'd1;
                                state      <= DIGIT;
                            end
                        end else begin
                            out_q <= stepped_out;
                            if (digit_wraps && has_higher) begin
                                digit_idx <= digit_idx + IDX_W'(1);
                                state     <= CARRY;
                            end else begin
                                if (digit_wraps)
                                    wrap_q <= 1'b1;
                                digit_idx <= '0;
                                if (steps_left == 4'd1) begin
                                    state <= DONE;
                                end else begin
                                    steps_left <= steps_left - 4'd1;
                                    state      <= DIGIT;
                                end
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Ready = ~bus.Request & (state == IDLE);
    assign bus.Out   = out_q;
    assign bus.Zero  = (out_q == '0);
    assign bus.AtTop = (out_q == LIMIT);
    assign bus.Wrap  = wrap_q;

endmodule

// File: tb/tb_dekatron_step_counter.sv
// Runs three counters (wrap-all, wrap-at-top, saturate) in lockstep against a decimal
// reference model, checking final values, flags, mode-0 ripple trace and latency.
module tb_dekatron_step_counter;

    localparam int DD      = 2;
    localparam int TOP_DEC = 555;
    localparam int MAX_DEC = 999;

    logic Clk;
    logic Rst_n;
    int   total;
    int   bad;
    int   mv[3];
    bit   mw[3];

    dekatron_step_counter_if #(.WIDTH(12)) bus0 ();
    dekatron_step_counter_if #(.WIDTH(12)) bus1 ();
    dekatron_step_counter_if #(.WIDTH(12)) bus2 ();

    dekatron_step_counter #(.LIMIT_MODE(0), .DIGIT_DELAY(DD)) u_mode0 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus0)
    );
    dekatron_step_counter #(.TOP_VALUE(12'h555), .LIMIT_MODE(1), .DIGIT_DELAY(DD)) u_mode1 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus1)
    );
    dekatron_step_counter #(.TOP_VALUE(12'h555), .LIMIT_MODE(2), .DIGIT_DELAY(DD)) u_mode2 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus2)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int k = 0; k < 3; k++) r[k*4 +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic int sanitize(input logic [11:0] v);
        int r = 0;
        for (int k = 0; k < 3; k++)
            if (v[k*4 +: 4] <= 4'd9) r += int'(v[k*4 +: 4]) * p10(k);
        return r;
    endfunction

    function automatic int limit_of(input int m);
        return (m == 0) ? MAX_DEC : TOP_DEC;
    endfunction

    // Decimal reference: whole unit steps with the limit rule of each mode.
    function automatic void model_op(input int m, input logic [1:0] op, input logic [3:0] step,
                                     input logic [11:0] in);
        int v = mv[m];
        int s = (step == 0) ? 1 : int'(step);
        mw[m] = 1'b0;
        if (op == 2'b11) begin
            v = 0;
        end else if (op == 2'b10) begin
            v = sanitize(in);
            if (m != 0 && v > TOP_DEC) v = TOP_DEC;
        end else begin
            for (int i = 0; i < s; i++) begin
                if (op == 2'b00 && v == limit_of(m)) begin
                    mw[m] = 1'b1;
                    if (m == 2) break;
                    v = 0;
                end else if (op == 2'b01 && v == 0) begin
                    mw[m] = 1'b1;
                    if (m == 2) break;
                    v = limit_of(m);
                end else begin
                    v = (op == 2'b00) ? v + 1 : v - 1;
                end
            end
        end
        mv[m] = v;
    endfunction

    task automatic drive_all(input logic req, input logic [1:0] op, input logic [3:0] step,
                             input logic [11:0] in);
        bus0.Request = req; bus0.Op = op; bus0.Step = step; bus0.In = in;
        bus1.Request = req; bus1.Op = op; bus1.Step = step; bus1.In = in;
        bus2.Request = req; bus2.Op = op; bus2.Step = step; bus2.In = in;
    endtask

    task automatic read_inst(input int m, output logic [11:0] o, output logic z, output logic a,
                             output logic w, output logic r);
        case (m)
            0:       begin o = bus0.Out; z = bus0.Zero; a = bus0.AtTop; w = bus0.Wrap; r = bus0.Ready; end
            1:       begin o = bus1.Out; z = bus1.Zero; a = bus1.AtTop; w = bus1.Wrap; r = bus1.Ready; end
            default: begin o = bus2.Out; z = bus2.Zero; a = bus2.AtTop; w = bus2.Wrap; r = bus2.Ready; end
        endcase
    endtask

    task automatic check_state(input string tag);
        logic [11:0] o;
        logic z, a, w, r;
        for (int m = 0; m < 3; m++) begin
            read_inst(m, o, z, a, w, r);
            checkOutput($sformatf("%s_m%0d_out", tag, m), o, to_bcd(mv[m]));
            checkOutput($sformatf("%s_m%0d_zero", tag, m), z, mv[m] == 0);
            checkOutput($sformatf("%s_m%0d_attop", tag, m), a, mv[m] == limit_of(m));
            checkOutput($sformatf("%s_m%0d_wrap", tag, m), w, mw[m]);
            checkOutput($sformatf("%s_m%0d_ready", tag, m), r, 1'b1);
        end
    endtask

    // One operation on all three counters, with a stray Request pulse mid-operation.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] step, input logic [11:0] in);
        int exp_trace[$];
        int got_trace[$];
        int v, d, nd, trans, exp_lat, lat, cyc;
        bit all_ready;
        logic [11:0] prev;
        v = mv[0];
        trans = 0;
        if (op[1]) begin
            trans = 1;
            nd = (op == 2'b11) ? 0 : sanitize(in);
            if (nd != v) exp_trace.push_back(nd);
        end else begin
            for (int s = 0; s < ((step == 0) ? 1 : int'(step)); s++) begin
                for (int k = 0; k < 3; k++) begin
                    d  = (v / p10(k)) % 10;
                    nd = (op == 2'b00) ? (d + 1) % 10 : (d + 9) % 10;
                    v  = v + (nd - d) * p10(k);
                    exp_trace.push_back(v);
                    trans++;
                    if (!((op == 2'b00) ? d == 9 : d == 0)) break;
                end
            end
        end
        exp_lat = 2 + DD * trans;
        for (int m = 0; m < 3; m++) model_op(m, op, step, in);

        @(negedge Clk);
        drive_all(1'b1, op, step, in);
        prev = bus0.Out;
        lat = 0;
        all_ready = 1'b0;
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (bus0.Out != prev) begin
                got_trace.push_back(sanitize(bus0.Out));
                prev = bus0.Out;
            end
            if (lat == 0 && bus0.Ready) lat = cyc;
            if (cyc > 3 && bus0.Ready && bus1.Ready && bus2.Ready) begin
                all_ready = 1'b1;
                break;
            end
            if (cyc == 1) drive_all(1'b0, 2'($urandom), 4'($urandom), 12'($urandom));
            if (cyc == 2) drive_all(1'b1, 2'b11, bus0.Step, bus0.In);
            if (cyc == 3) drive_all(1'b0, bus0.Op, bus0.Step, bus0.In);
        end
        checkOutput("ready_seen", all_ready, 1'b1);
        checkOutput("m0_latency", lat, exp_lat);
        checkOutput("m0_trace_len", got_trace.size(), exp_trace.size());
        for (int i = 0; i < exp_trace.size() && i < got_trace.size(); i++)
            checkOutput($sformatf("m0_trace_%0d", i), got_trace[i], exp_trace[i]);
        check_state($sformatf("op%0d", op));
    endtask

    // Reset lands while the 099 -> 100 carry is still rippling.
    task automatic reset_mid_carry();
        logic [11:0] o;
        logic z, a, w, r;
        applyStimulus(2'b10, 4'd0, 12'h099);
        @(negedge Clk);
        drive_all(1'b1, 2'b00, 4'd1, 12'h000);
        @(posedge Clk); #1;
        drive_all(1'b0, 2'b00, 4'd1, 12'h000);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        for (int m = 0; m < 3; m++) begin
            read_inst(m, o, z, a, w, r);
            checkOutput($sformatf("ripple_mid_m%0d", m), o, 12'h090);
        end
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            mv[m] = 0;
            mw[m] = 1'b0;
        end
        check_state("in_reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check_state("after_reset");
    endtask

    initial begin
        int near[7];
        logic [11:0] in;
        near = '{0, 1, 554, 555, 556, 998, 999};
        total = 0;
        bad   = 0;
        Clk   = 1'b0;
        Rst_n = 1'b0;
        for (int m = 0; m < 3; m++) begin
            mv[m] = 0;
            mw[m] = 1'b0;
        end
        drive_all(1'b0, 2'b00, 4'd0, 12'h000);
        #23;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_state("reset");

        applyStimulus(2'b10, 4'd0, 12'h199);
        applyStimulus(2'b00, 4'd1, 12'h000);
        applyStimulus(2'b10, 4'd0, 12'h998);
        applyStimulus(2'b00, 4'd3, 12'h000);
        applyStimulus(2'b10, 4'd0, 12'h555);
        applyStimulus(2'b00, 4'd1, 12'h000);
        applyStimulus(2'b01, 4'd1, 12'h000);
        applyStimulus(2'b10, 4'd0, 12'h553);
        applyStimulus(2'b00, 4'd5, 12'h000);
        applyStimulus(2'b11, 4'd0, 12'h000);
        applyStimulus(2'b01, 4'd0, 12'h000);
        applyStimulus(2'b10, 4'd0, 12'h7A3);
        applyStimulus(2'b11, 4'd0, 12'h123);
        reset_mid_carry();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) in = 12'($urandom);
            else in = to_bcd(near[$urandom_range(0, 6)]);
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), in);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
